// File: rtl/tl_a_channel_rr_arbiter_if.sv
// TileLink A-channel bundle: N packed requester lanes in, one merged lane out.
// slave = arbiter view, master = requesters plus downstream sink.
interface tl_a_channel_rr_arbiter_if #(
  parameter int N        = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SOURCE_W = 4
);
  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N);

  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [3*N-1:0]          in_opcode;
  logic [3*N-1:0]          in_param;
  logic [3*N-1:0]          in_size;
  logic [SOURCE_W*N-1:0]   in_source;
  logic [ADDR_W*N-1:0]     in_address;
  logic [MASK_W*N-1:0]     in_mask;
  logic [DATA_W*N-1:0]     in_data;

  logic                    out_valid;
  logic                    out_ready;
  logic [2:0]              out_opcode;
  logic [2:0]              out_param;
  logic [2:0]              out_size;
  logic [SOURCE_W+IDX_W-1:0] out_source;
  logic [ADDR_W-1:0]       out_address;
  logic [MASK_W-1:0]       out_mask;
  logic [DATA_W-1:0]       out_data;

  modport slave (
    input  in_valid, in_opcode, in_param, in_size,
    input  in_source, in_address, in_mask, in_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_opcode, out_param, out_size,
    output out_source, out_address, out_mask, out_data
  );

  modport master (
    output in_valid, in_opcode, in_param, in_size,
    output in_source, in_address, in_mask, in_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_opcode, out_param, out_size,
    input  out_source, out_address, out_mask, out_data
  );
endinterface

// File: rtl/tl_a_channel_rr_arbiter.sv
// Round-robin merge of N TL-UL/UH A channels; grant held for whole bursts.
// Ports: clock, reset (sync, active-high), bus (slave), busy, grant_idx.
module tl_a_channel_rr_arbiter #(
  parameter int N        = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SOURCE_W = 4,
  parameter int MAX_SIZE = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_a_channel_rr_arbiter_if.slave bus,
  output logic                  busy,
  output logic [$clog2(N)-1:0]  grant_idx
);
  localparam int MASK_W  = DATA_W / 8;
  localparam int IDX_W   = $clog2(N);
  localparam int LG_MASK = $clog2(MASK_W);
  localparam int CNT_W   =
    (MAX_SIZE > LG_MASK) ? MAX_SIZE - LG_MASK + 1 : 1;
  // Wide enough for 1 << 7 from any 3-bit size.
  localparam int BEAT_W  = 9;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [CNT_W-1:0]   beats_left_q, beats_left_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [IDX_W-1:0]   sel_idx;
  int unsigned        sel_i;
  logic [2:0]         sel_op;
  logic [2:0]         sel_size;
  logic [SOURCE_W-1:0] sel_src;
  logic [BEAT_W-1:0]  beats;
  logic               fire;

  // Scan starts one past the previous winner so everyone gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_found &&
          bus.in_valid[(int'(last_idx_q) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(last_idx_q) + k) % N);
      end
    end
  end

  assign sel_idx  = (state_q == BURST) ? lock_idx_q : win_idx;
  assign sel_i    = 32'(sel_idx);
  assign sel_op   = bus.in_opcode[sel_i*3 +: 3];
  assign sel_size = bus.in_size[sel_i*3 +: 3];
  assign sel_src  = bus.in_source[sel_i*SOURCE_W +: SOURCE_W];

  assign bus.out_opcode  = sel_op;
  assign bus.out_param   = bus.in_param[sel_i*3 +: 3];
  assign bus.out_size    = sel_size;
  assign bus.out_source  = {sel_idx, sel_src};
  assign bus.out_address = bus.in_address[sel_i*ADDR_W +: ADDR_W];
  assign bus.out_mask    = bus.in_mask[sel_i*MASK_W +: MASK_W];
  assign bus.out_data    = bus.in_data[sel_i*DATA_W +: DATA_W];

  // Opcodes 0..3 carry data; those wider than the bus span several beats.
  always_comb begin
    beats = BEAT_W'(1);
    if (!sel_op[2] && (sel_size > 3'(LG_MASK)))
      beats = BEAT_W'(1) << (sel_size - 3'(LG_MASK));
  end

  assign fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_idx_q   <= '0;
      last_idx_q   <= LAST_RST;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_idx_q   <= lock_idx_d;
      last_idx_q   <= last_idx_d;
      beats_left_q <= beats_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_idx_d   = lock_idx_q;
    last_idx_d   = last_idx_q;
    beats_left_d = beats_left_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          last_idx_d = win_idx;
          if (beats > BEAT_W'(1)) begin
            lock_idx_d   = win_idx;
            beats_left_d = CNT_W'(beats - BEAT_W'(1));
            state_d      = BURST;
          end
        end
      end
      BURST: begin
        if (fire) begin
          beats_left_d = beats_left_q - CNT_W'(1);
          if (beats_left_q == CNT_W'(1))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid never depends on out_ready; only in_ready does.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.in_ready  = '0;
    busy          = (state_q == BURST);
    grant_idx     = sel_idx;
    if (!reset) begin
      unique case (state_q)
        BURST: begin
          bus.out_valid           = bus.in_valid[lock_idx_q];
          bus.in_ready[lock_idx_q] = bus.out_ready;
        end
        default: begin
          if (win_found) begin
            bus.out_valid         = 1'b1;
            bus.in_ready[win_idx] = bus.out_ready;
          end
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [2:0]          chk_op_q;
  logic [SOURCE_W-1:0] chk_src_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (bus.out_valid && (32'(sel_size) > MAX_SIZE)) begin
        $display("tl_a_channel_rr_arbiter: size %0d > %0d",
          sel_size, MAX_SIZE);
        $fatal(1, "illegal A-channel size");
      end
      if (state_q == BURST && bus.in_valid[lock_idx_q] &&
          (sel_op != chk_op_q || sel_src != chk_src_q)) begin
        $display("tl_a_channel_rr_arbiter: burst header changed");
        $fatal(1, "opcode/source changed mid-burst");
      end
      if (state_q == IDLE && fire) begin
        chk_op_q  <= sel_op;
        chk_src_q <= sel_src;
      end
    end
  end
`endif
endmodule

// File: tb/tb_tl_a_channel_rr_arbiter.sv
// Randomised + directed bench with a cycle-level scoreboard.
// A predictor pushes expectations; a monitor pops and compares.
module tb_tl_a_channel_rr_arbiter;
  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int MW  = DW / 8;
  localparam int IW  = $clog2(N);
  localparam int LGM = $clog2(MW);

  logic clk;
  logic rst;
  logic busy;
  logic [IW-1:0] grant_idx;

  tl_a_channel_rr_arbiter_if #(
    .N(N), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW)
  ) bus ();

  tl_a_channel_rr_arbiter #(
    .N(N), .ADDR_W(AW), .DATA_W(DW),
    .SOURCE_W(SW), .MAX_SIZE(6)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus),
    .busy(busy),
    .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [2:0]    par;
    logic [2:0]    sz;
    logic [SW-1:0] src;
    logic [AW-1:0] addr;
    logic [DW-1:0] dbase;
    logic [MW-1:0] mask;
  } txn_t;

  typedef struct {
    bit            rst;
    bit            valid;
    logic [N-1:0]  rdy;
    bit            busy;
    int            sel;
    logic [2:0]    op;
    logic [2:0]    par;
    logic [2:0]    sz;
    logic [SW+IW-1:0] src;
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } exp_t;

  txn_t pend [N][$];
  txn_t cur  [N];
  bit   has  [N];
  int   sent [N];
  exp_t sbq  [$];

  int m_lock = -1;
  int m_last = N - 1;
  int m_rem  = 0;

  int compared = 0;
  int mismatched = 0;

  function automatic int nbeats(input txn_t t);
    if (t.op < 3'd4 && int'(t.sz) > LGM)
      return 1 << (int'(t.sz) - LGM);
    return 1;
  endfunction

  function automatic txn_t mk_txn(
    input logic [2:0] op, input logic [2:0] sz
  );
    txn_t t;
    t.op    = op;
    t.sz    = sz;
    t.par   = 3'($urandom_range(0, 7));
    t.src   = SW'($urandom);
    t.addr  = $urandom;
    t.dbase = $urandom;
    t.mask  = MW'($urandom);
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [2:0] op;
    op = 3'($urandom_range(0, 5));
    return mk_txn(op, 3'($urandom_range(0, 6)));
  endfunction

  task automatic chk(
    input string nm, input logic [63:0] act, input logic [63:0] exp
  );
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, predict, then note handshakes.
  task automatic cycle(
    input bit r, input bit rdy, input logic [N-1:0] hold
  );
    logic [N-1:0]    v;
    logic [3*N-1:0]  op, pr, sz;
    logic [SW*N-1:0] src;
    logic [AW*N-1:0] ad;
    logic [DW*N-1:0] dt;
    logic [MW*N-1:0] mk;
    exp_t e;
    int sel;
    @(negedge clk);
    v = '0; op = '0; pr = '0; sz = '0;
    src = '0; ad = '0; dt = '0; mk = '0;
    for (int i = 0; i < N; i++) begin
      if (!has[i] && pend[i].size() > 0) begin
        cur[i]  = pend[i].pop_front();
        has[i]  = 1'b1;
        sent[i] = 0;
      end
      if (has[i]) begin
        v[i] = !(hold[i] && sent[i] > 0);
        op[3*i +: 3]   = cur[i].op;
        pr[3*i +: 3]   = cur[i].par;
        sz[3*i +: 3]   = cur[i].sz;
        src[SW*i +: SW] = cur[i].src;
        ad[AW*i +: AW] = cur[i].addr;
        dt[DW*i +: DW] = cur[i].dbase + DW'(sent[i]);
        mk[MW*i +: MW] = cur[i].mask;
      end
    end
    rst = r;
    bus.out_ready  = rdy;
    bus.in_valid   = v;
    bus.in_opcode  = op;
    bus.in_param   = pr;
    bus.in_size    = sz;
    bus.in_source  = src;
    bus.in_address = ad;
    bus.in_data    = dt;
    bus.in_mask    = mk;
    #1;
    e = '{default: '0};
    e.rst = r;
    if (r) begin
      m_lock = -1;
      m_last = N - 1;
      m_rem  = 0;
    end else begin
      sel = -1;
      if (m_lock >= 0) sel = m_lock;
      else
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (sel < 0 && v[j]) sel = j;
        end
      e.busy = (m_lock >= 0);
      e.sel  = sel;
      if (sel >= 0) begin
        e.valid    = v[sel];
        e.rdy[sel] = rdy;
        e.op   = cur[sel].op;
        e.par  = cur[sel].par;
        e.sz   = cur[sel].sz;
        e.src  = {IW'(sel), cur[sel].src};
        e.addr = cur[sel].addr;
        e.mask = cur[sel].mask;
        e.data = cur[sel].dbase + DW'(sent[sel]);
      end
      if (e.valid && rdy) begin
        if (m_lock >= 0) begin
          m_rem--;
          if (m_rem == 0) m_lock = -1;
        end else begin
          m_last = sel;
          if (nbeats(cur[sel]) > 1) begin
            m_lock = sel;
            m_rem  = nbeats(cur[sel]) - 1;
          end
        end
      end
    end
    sbq.push_back(e);
    #2;
    for (int i = 0; i < N; i++) begin
      if (r) sent[i] = 0;
      else if (bus.in_valid[i] && bus.in_ready[i]) begin
        sent[i]++;
        if (sent[i] >= nbeats(cur[i])) has[i] = 1'b0;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("out_valid", 64'(bus.out_valid), 64'(e.valid));
        chk("in_ready", 64'(bus.in_ready), 64'(e.rdy));
        if (!e.rst)
          chk("busy", 64'(busy), 64'(e.busy));
        if (e.valid) begin
          chk("grant_idx", 64'(grant_idx), 64'(e.sel));
          chk("out_source", 64'(bus.out_source), 64'(e.src));
          chk("out_opcode", 64'(bus.out_opcode), 64'(e.op));
          chk("out_param", 64'(bus.out_param), 64'(e.par));
          chk("out_size", 64'(bus.out_size), 64'(e.sz));
          chk("out_address", 64'(bus.out_address), 64'(e.addr));
          chk("out_mask", 64'(bus.out_mask), 64'(e.mask));
          chk("out_data", 64'(bus.out_data), 64'(e.data));
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((has[0] || has[1] || pend[0].size() > 0 ||
            pend[1].size() > 0) && n < 300) begin
      cycle(1'b0, 1'b1, '0);
      n++;
    end
    compared++;
    if (n >= 300) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d cycles limit 300", n);
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, '0);
    cycle(1'b1, 1'b1, '0);
  endtask

  initial begin : stim
    int hc;
    logic h;
    rst = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      has[i] = 1'b0;
      sent[i] = 0;
    end
    do_reset();
    cycle(1'b0, 1'b1, '0);

    // Alternating single-beat Gets.
    for (int k = 0; k < 4; k++) begin
      pend[0].push_back(mk_txn(3'd4, 3'd2));
      pend[1].push_back(mk_txn(3'd4, 3'd2));
    end
    drain();

    // 16-beat PutFull from req0 blocks req1's Get.
    do_reset();
    pend[0].push_back(mk_txn(3'd0, 3'd6));
    pend[1].push_back(mk_txn(3'd4, 3'd2));
    drain();

    // Same burst with out_ready toggling.
    do_reset();
    pend[0].push_back(mk_txn(3'd0, 3'd6));
    pend[1].push_back(mk_txn(3'd4, 3'd2));
    for (int k = 0; k < 40; k++)
      cycle(1'b0, k[0] == 1'b0, '0);
    drain();

    // req0 drops valid for 3 cycles after beat 5.
    do_reset();
    pend[0].push_back(mk_txn(3'd0, 3'd6));
    pend[1].push_back(mk_txn(3'd4, 3'd2));
    hc = 0;
    for (int k = 0; k < 30; k++) begin
      h = (sent[0] == 5 && hc < 3);
      if (h) hc++;
      cycle(1'b0, 1'b1, {1'b0, h});
    end
    drain();

    // Reset in the middle of a burst.
    do_reset();
    pend[0].push_back(mk_txn(3'd1, 3'd6));
    pend[1].push_back(mk_txn(3'd4, 3'd2));
    for (int k = 0; k < 40 && sent[0] != 8; k++)
      cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, '0);
    drain();

    // Only req1, short PutFulls.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pend[1].push_back(mk_txn(3'd0, 3'd2));
      pend[1].push_back(mk_txn(3'd0, 3'd1));
    end
    drain();

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++)
        if (pend[i].size() == 0 && $urandom_range(0, 2) == 0)
          pend[i].push_back(rand_txn());
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0,
            N'($urandom_range(0, 7) == 0 ? $urandom : 0));
    end
    drain();

    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_left: got %0d expected 0",
               sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
